// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, limits and parity helper for the rx/tx frame blocks.
package uart_pkg;

    localparam int UART_DIV_MIN    = 8;
    localparam int UART_DATA_W_MAX = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Expected parity bit for a zero-extended word; odd=1 selects odd parity.
    function automatic logic parity_calc(input logic [UART_DATA_W_MAX-1:0] data, input logic odd);
        return ^data ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer plus delay flop; flags the falling edge of the line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_d;

    // Reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_d  <= 1'b1;
        end else begin
            r_s1 <= i_rx;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    assign o_rx_s = r_s2;
    assign o_fall = r_d & ~r_s2;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: LSB-first UART receiver with mid-bit sampling, glitch rejection and error flags.
// Define UART_RX_PARITY_EN to expect and check one parity bit after the data bits.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_frame_err,
    output logic              o_parity_err,
    output logic              o_busy
);

    localparam int DIV = (CLK_DIV < UART_DIV_MIN) ? UART_DIV_MIN : CLK_DIV;
    localparam int CW  = $clog2(DIV);
    localparam int IW  = $clog2(DATA_W);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

    logic                w_rx_s;
    logic                w_fall;
    logic                w_half;
    logic                w_full;
    logic                w_last_bit;
    logic                w_last_stop;
    logic                w_done;
    uart_rx_state_t      r_state;
    uart_rx_state_t      w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic                r_stop_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_ferr_acc;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_ferr;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rx   (i_rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    assign w_half      = r_cnt == HALF;
    assign w_full      = r_cnt == FULL;
    assign w_last_bit  = r_idx == IW'(DATA_W - 1);
    assign w_last_stop = r_stop_idx == 1'(STOP_BITS - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE:   if (w_fall) w_state_nxt = START;
            START:  if (w_half) w_state_nxt = w_rx_s ? IDLE : DATA;
            DATA:   if (w_full && w_last_bit) w_state_nxt = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY: if (w_full) w_state_nxt = STOP;
`endif
            STOP: begin
                if (w_full && w_last_stop) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_ferr_acc <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state || w_full || r_state == IDLE) ? '0 : r_cnt + 1'b1;
            r_valid <= w_done;
            if (r_state == START) begin
                r_idx      <= '0;
                r_stop_idx <= 1'b0;
                r_ferr_acc <= 1'b0;
            end
            // Shifting in at the MSB leaves the first data bit at the LSB after DATA_W samples.
            if (r_state == DATA && w_full) begin
                r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
                r_idx   <= r_idx + 1'b1;
            end
            if (r_state == STOP && w_full) begin
                r_stop_idx <= r_stop_idx + 1'b1;
                if (!w_rx_s) r_ferr_acc <= 1'b1;
            end
            if (w_done) begin
                r_data <= r_shift;
                r_ferr <= r_ferr_acc | ~w_rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr_acc;
    logic r_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr_acc <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            if (r_state == START) r_perr_acc <= 1'b0;
            if (r_state == PARITY && w_full)
                r_perr_acc <= w_rx_s != parity_calc(UART_DATA_W_MAX'(r_shift), 1'(PARITY_ODD));
            if (w_done) r_perr <= r_perr_acc;
        end
    end

    assign o_parity_err = r_perr;
`else
    logic w_unused_parity_odd;

    assign w_unused_parity_odd = 1'(PARITY_ODD);
    assign o_parity_err        = 1'b0;
`endif

    assign o_rx_data   = r_data;
    assign o_rx_valid  = r_valid;
    assign o_frame_err = r_ferr;
    assign o_busy      = r_state != IDLE;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames into an 8N1 and a 7-bit/2-stop receiver with hand-computed strobe times.
module tb_uart_rx_frame;

    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx1   = 1'b1;
    logic       rx2   = 1'b1;
    logic [7:0] d1;
    logic       v1, fe1, pe1, b1;
    logic [6:0] d2;
    logic       v2, fe2, pe2, b2;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n1 = 0, n2 = 0, t1 = 0, t2a = 0, t2b = 0, fall1 = -1;
    logic [7:0] cd1;
    logic       cfe1, cpe1, pb1 = 1'b0, cfe2 = 1'b0;
    logic [6:0] cd2_0, cd2_1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame #(.CLK_DIV(DIV), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_rx(rx1), .o_rx_data(d1), .o_rx_valid(v1),
        .o_frame_err(fe1), .o_parity_err(pe1), .o_busy(b1)
    );

    uart_rx_frame #(.CLK_DIV(DIV), .DATA_W(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_rx(rx2), .o_rx_data(d2), .o_rx_valid(v2),
        .o_frame_err(fe2), .o_parity_err(pe2), .o_busy(b2)
    );

    // Strobe/busy monitor; cyc holds the index of the most recent rising edge.
    always @(negedge clk) begin
        if (v1) begin
            n1++;
            t1   = cyc;
            cd1  = d1;
            cfe1 = fe1;
            cpe1 = pe1;
        end
        if (v2) begin
            if (n2 == 0) begin
                t2a   = cyc;
                cd2_0 = d2;
            end else begin
                t2b   = cyc;
                cd2_1 = d2;
            end
            cfe2 = cfe2 | fe2;
            n2++;
        end
        if (pb1 && !b1) fall1 = cyc;
        pb1 = b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int sel, input logic b, input int n);
        if (sel == 1) rx1 = b;
        else rx2 = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; e0 is the edge that first captures the start bit.
    task automatic send(input int sel, input logic [8:0] data, input int nd, input int ns,
                        input logic par, input logic stop_v, output int e0);
        e0 = cyc + 1;
        hold(sel, 1'b0, DIV);
        for (int i = 0; i < nd; i++) hold(sel, data[i], DIV);
        if (P == 1) hold(sel, par, DIV);
        for (int i = 0; i < ns; i++) hold(sel, stop_v, DIV);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, n0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", d1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_ferr", fe1, 0);
        chk("rst_perr", pe1, 0);
        chk("rst_busy", b1, 0);
        rst_n = 1'b1;
        hold(1, 1'b1, 5);

        send(1, 9'hA5, 8, 1, 1'b0, 1'b1, e0);
        hold(1, 1'b1, 20);
        chk("a5_count", n1, 1);
        chk("a5_time", t1, e0 + 10 + DIV * (9 + P));
        chk("a5_data", cd1, 8'hA5);
        chk("a5_ferr", cfe1, 0);
        chk("a5_perr", cpe1, 0);
        chk("a5_busy", b1, 0);

        n0 = n1;
        e0 = cyc + 1;
        hold(1, 1'b0, 5);
        hold(1, 1'b1, 30);
        chk("glitch_nostrobe", n1, n0);
        chk("glitch_busy_fall", fall1, e0 + 10);
        send(1, 9'h3C, 8, 1, 1'b0, 1'b1, e0);
        hold(1, 1'b1, 20);
        chk("3c_count", n1, n0 + 1);
        chk("3c_time", t1, e0 + 10 + DIV * (9 + P));
        chk("3c_data", cd1, 8'h3C);
        chk("3c_ferr", cfe1, 0);

        n0 = n1;
        send(1, 9'h55, 8, 1, 1'b0, 1'b0, e0);
        hold(1, 1'b0, 40 * DIV);
        chk("break_count", n1, n0 + 1);
        chk("break_time", t1, e0 + 10 + DIV * (9 + P));
        chk("break_data", cd1, 8'h55);
        chk("break_ferr", cfe1, 1);
        chk("break_busy", b1, 0);
        hold(1, 1'b1, 40);
        chk("break_release", n1, n0 + 1);

        send(2, 9'h7F, 7, 2, 1'b1, 1'b1, e0);
        send(2, 9'h01, 7, 2, 1'b1, 1'b1, e1);
        hold(2, 1'b1, 20);
        chk("b2b_count", n2, 2);
        chk("b2b_time0", t2a, e0 + 10 + DIV * (9 + P));
        chk("b2b_gap", t2b - t2a, DIV * (10 + P));
        chk("b2b_data0", cd2_0, 7'h7F);
        chk("b2b_data1", cd2_1, 7'h01);
        chk("b2b_ferr", cfe2, 0);

`ifdef UART_RX_PARITY_EN
        send(1, 9'h03, 8, 1, 1'b0, 1'b1, e0);
        hold(1, 1'b1, 20);
        chk("par03_time", t1, e0 + 170);
        chk("par03_data", cd1, 8'h03);
        chk("par03_perr", cpe1, 0);
        send(1, 9'h07, 8, 1, 1'b0, 1'b1, e0);
        hold(1, 1'b1, 20);
        chk("par07_time", t1, e0 + 170);
        chk("par07_data", cd1, 8'h07);
        chk("par07_perr", cpe1, 1);
`endif

        n0 = n1;
        send(1, 9'h1FF, 8, 1, 1'b0, 1'b0, e0);
        hold(1, 1'b1, 20);
        chk("pre_rst_ferr", fe1, 1);
        n0 = n1;
        hold(1, 1'b0, DIV * 5 + DIV / 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", d1, 0);
        chk("midrst_valid", v1, 0);
        chk("midrst_ferr", fe1, 0);
        chk("midrst_perr", pe1, 0);
        chk("midrst_busy", b1, 0);
        hold(1, 1'b1, 5);
        rst_n = 1'b1;
        hold(1, 1'b1, 10 * DIV);
        chk("midrst_nostrobe", n1, n0);
        chk("midrst_idle", b1, 0);
        send(1, 9'hC3, 8, 1, 1'b0, 1'b1, e0);
        hold(1, 1'b1, 20);
        chk("c3_count", n1, n0 + 1);
        chk("c3_time", t1, e0 + 10 + DIV * (9 + P));
        chk("c3_data", cd1, 8'hC3);
        chk("c3_ferr", cfe1, 0);
        chk("c3_perr", cpe1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that turns the asynchronous serial line into parallel words for the SDRAM loopback path and other byte consumers. Configurable clock divisor, word width and stop-bit count. LSB-first, mid-bit sampling with start-bit glitch rejection. Flags framing errors and, optionally, parity errors. Emits a one-cycle `rx_valid` strobe per received frame.

## Interface
- `CLK_DIV`, 5208: clocks per bit; legal 8..65535; simulation uses 16.
- `DATA_W`, 8: data bits per frame; legal 5..9.
- `STOP_BITS`, 1: stop bits checked; legal 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; only used when parity is compiled in.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `rx`, in, 1: asynchronous serial line; idles high.
- `rx_data`, out, DATA_W: last received word, LSB = first data bit; held until the next `rx_valid`.
- `rx_valid`, out, 1: one-cycle strobe; `rx_data` and the error flags are valid in this cycle.
- `frame_err`, out, 1: a stop bit sampled low; registered with `rx_valid`, held until the next `rx_valid`.
- `parity_err`, out, 1: parity mismatch; same registering and hold as `frame_err`.
- `busy`, out, 1: high whenever the FSM is not IDLE.

## Operation
- Input path: `rx` passes through 2-FF synchronizer `rx_s`, then delay flop `rx_d`. All three flops reset to 1, so reset never produces a false start edge. Falling edge: `rx_d & ~rx_s`.
- Baud counter `cnt`: width `$clog2(CLK_DIV)`. Cleared on every state entry. Increments every cycle outside IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge, go to START with `cnt` = 0.
- START: at `cnt == CLK_DIV/2-1`, sample `rx_s`.
  - If 0: go to DATA with `cnt` = 0 and bit index = 0.
  - If 1: glitch; return to IDLE with no strobe and no flag change.
- DATA: at `cnt == CLK_DIV-1`, shift `rx_s` into bit `idx` of the shift register. After `DATA_W` samples, go to PARITY if parity is compiled in, otherwise to STOP.
- PARITY: at `cnt == CLK_DIV-1`, sample the parity bit. Parity error = (XOR of data ^ sampled bit) != `PARITY_ODD`.
- STOP: at `cnt == CLK_DIV-1`, sample the stop bit; any low sample sets the frame-error accumulator. After `STOP_BITS` samples:
  - register `rx_data`, `frame_err` and `parity_err`;
  - pulse `rx_valid`;
  - return to IDLE.
- A frame with an error still delivers `rx_data` and `rx_valid`; the flags qualify it.
- Break (line held low): the frame ends with `frame_err` = 1. No new start is accepted until `rx_s` returns high and falls again.
- Falling edges outside IDLE are ignored.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0, FSM = IDLE, `cnt` = 0.
- Let E0 be the clock edge that first captures `rx` low.
- START is entered at E0+2; `busy` rises in the same cycle.
- Start sample occurs at E0+2+CLK_DIV/2-1. Each later sample occurs CLK_DIV cycles after the previous one.
- N = DATA_W + STOP_BITS + P, where P = 1 with parity and 0 without.
- `rx_valid` is high for exactly one cycle, at E0+2+CLK_DIV/2+N·CLK_DIV. `busy` is low in that same cycle.
- Back-to-back frames: a start edge arriving as early as the cycle `rx_valid` is high is accepted. This tolerates a stop bit up to half a bit short.
- Reset mid-frame: all state clears immediately, with no strobe. The next frame requires a fresh falling edge.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists; one parity bit per frame is expected and checked per `PARITY_ODD`; `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: no PARITY state; frames contain no parity bit; `parity_err` is a constant 0 (the port remains); `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE/START/DATA/PARITY/STOP);
  - localparams `UART_DIV_MIN` = 8 and `UART_DATA_W_MAX` = 9;
  - helper function `parity_calc` (XOR reduction plus odd/even select), shared with the future `uart_tx_frame`.
- Sub-module `uart_rx_sync`: 2-FF synchronizer, delay flop and falling-edge detect. Reset value 1. Outputs `rx_s` and `fall`.

## Test plan
All scenarios use CLK_DIV = 16.

1. Single frame, DATA_W=8, STOP_BITS=1, no parity. Send 0xA5 LSB-first → `rx_data` = 0xA5; `rx_valid` one cycle at E0+2+8+9·16 = E0+154; `frame_err` = 0.
2. Glitch: `rx` low for 5 clocks, then high → no `rx_valid`; `busy` drops at E0+2+8; a following 0x3C frame is received correctly.
3. Framing error: send 0x55 with the stop bit driven low, then hold low 40 bit-times → one `rx_valid` with `frame_err` = 1 and `rx_data` = 0x55; no further frames until the line returns high.
4. Back-to-back, STOP_BITS=2, DATA_W=7: send 0x7F then 0x01 with no idle gap → two strobes 10·16 cycles apart; data 0x7F, then 0x01.
5. `UART_RX_PARITY_EN` defined, PARITY_ODD=0:
   - 0x03 with parity bit 0 → `parity_err` = 0;
   - 0x07 with parity bit 0 → `parity_err` = 1;
   - strobe at E0+170 in both cases.
6. Reset asserted mid-data-bit 4 → all outputs 0 immediately; after release, a fresh 0xC3 frame is received with no errors.
